ld_st_buffer: RTL and testbench

- In-order load/store queue between the issuer and the memory controller.
- Captures operands from the rss and lsb buses and issues one memory request at a time from its head.
- Broadcasts load results on the lsb bus, which feeds the reorder buffer, the reservation stations and itself.
- Stores go to memory only after the reorder buffer announces their commit on the rob bus. Uncommitted entries are discarded on rob-bus reset.

---
 rtl/ld_st_buffer_pkg.sv | 22 ++
 rtl/ld_st_buffer_load_extender.sv | 23 ++
 rtl/ld_st_buffer.sv | 248 ++++++++++++++++++++++++
 tb/tb_ld_st_buffer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_st_buffer_pkg.sv
// Shared constants and types for the in-order load/store buffer.
package ld_st_buffer_pkg;

  localparam int LSB_SIZE_DEFAULT = 8;
  typedef logic [$clog2(LSB_SIZE_DEFAULT)-1:0] lsb_id_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    DRAIN    = 2'd2
  } lsb_state_e;

endpackage

// File: rtl/ld_st_buffer_load_extender.sv
// Sign/zero extension of LSB-aligned raw load data according to funct3.
module load_extender
  import ld_st_buffer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] value
);

  always_comb begin
    value = raw;
    case (funct3)
      F3_LB:   value = {{(XLEN-8){raw[7]}}, raw[7:0]};
      F3_LH:   value = {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_LBU:  value = {{(XLEN-8){1'b0}}, raw[7:0]};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/ld_st_buffer.sv
// In-order load/store queue: captures operands, issues one memory request at a
// time from the head, broadcasts load results, and survives ROB flushes.
//
// state    | meaning
// IDLE     | no request outstanding; head is checked for issue
// WAIT_MEM | request on the memory port, waiting for done
// DRAIN    | flushed load still in flight; result is dropped on done
module ld_st_buffer
  import ld_st_buffer_pkg::*;
#(
  parameter int LSB_SIZE = LSB_SIZE_DEFAULT,
  parameter int ROB_ID_W = 4,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  output logic                is_lsb_full,
  input  logic                valid_from_issuer,
  input  logic                is_store_from_issuer,
  input  logic [2:0]          funct3_from_issuer,
  input  logic [ROB_ID_W-1:0] dest_from_issuer,
  input  logic [ROB_ID_W-1:0] qj_from_issuer,
  input  logic [XLEN-1:0]     vj_from_issuer,
  input  logic [ROB_ID_W-1:0] qk_from_issuer,
  input  logic [XLEN-1:0]     vk_from_issuer,
  input  logic [XLEN-1:0]     imm_from_issuer,
  input  logic [ROB_ID_W-1:0] dest_from_rss_bus,
  input  logic [XLEN-1:0]     value_from_rss_bus,
  output logic [ROB_ID_W-1:0] dest_to_lsb_bus,
  output logic [XLEN-1:0]     value_to_lsb_bus,
  input  logic                reset_from_rob_bus,
  input  logic [ROB_ID_W-1:0] dest_from_rob_bus,
  output logic                valid_to_mem,
  output logic                is_write_to_mem,
  output logic [XLEN-1:0]     addr_to_mem,
  output logic [XLEN-1:0]     data_to_mem,
  output logic [2:0]          funct3_to_mem,
  input  logic                done_from_mem,
  input  logic [XLEN-1:0]     data_from_mem
);

  localparam int IDX_W = $clog2(LSB_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [LSB_SIZE-1:0] busy, is_store, committed;
  logic [2:0]          e_funct3 [LSB_SIZE];
  logic [ROB_ID_W-1:0] e_dest   [LSB_SIZE];
  logic [ROB_ID_W-1:0] e_qj     [LSB_SIZE];
  logic [ROB_ID_W-1:0] e_qk     [LSB_SIZE];
  logic [XLEN-1:0]     e_vj     [LSB_SIZE];
  logic [XLEN-1:0]     e_vk     [LSB_SIZE];
  logic [XLEN-1:0]     e_imm    [LSB_SIZE];

  logic [IDX_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  lsb_state_e       state, state_nxt;

  logic                flush, enq, issue, pop, bcast, head_ready, enq_commit;
  logic [LSB_SIZE-1:0] commit_hit, keep;
  logic [CNT_W-1:0]    ncommitted;
  logic [ROB_ID_W-1:0] enq_qj, enq_qk;
  logic [XLEN-1:0]     enq_vj, enq_vk, ext_value;

  assign flush       = reset_from_rob_bus;
  assign enq         = valid_from_issuer && !flush;
  assign is_lsb_full = (count >= CNT_W'(LSB_SIZE - 1));
  assign enq_commit  = is_store_from_issuer && (dest_from_rob_bus != '0) &&
                       (dest_from_issuer == dest_from_rob_bus);
  assign head_ready  = busy[head] && (e_qj[head] == '0) &&
                       (!is_store[head] || ((e_qk[head] == '0) && committed[head]));

  load_extender #(.XLEN(XLEN)) u_ext (
    .funct3 (funct3_to_mem),
    .raw    (data_from_mem),
    .value  (ext_value)
  );

  // Operands resolved by a broadcast in the enqueue cycle itself.
  always_comb begin
    enq_qj = qj_from_issuer;
    enq_vj = vj_from_issuer;
    enq_qk = qk_from_issuer;
    enq_vk = vk_from_issuer;
    if (qj_from_issuer != '0 && qj_from_issuer == dest_from_rss_bus) begin
      enq_qj = '0;
      enq_vj = value_from_rss_bus;
    end else if (qj_from_issuer != '0 && qj_from_issuer == dest_to_lsb_bus) begin
      enq_qj = '0;
      enq_vj = value_to_lsb_bus;
    end
    if (qk_from_issuer != '0 && qk_from_issuer == dest_from_rss_bus) begin
      enq_qk = '0;
      enq_vk = value_from_rss_bus;
    end else if (qk_from_issuer != '0 && qk_from_issuer == dest_to_lsb_bus) begin
      enq_qk = '0;
      enq_vk = value_to_lsb_bus;
    end
    if (!is_store_from_issuer) enq_qk = '0;
  end

  // Committed stores form a prefix from head, so a popcount gives its length.
  always_comb begin
    commit_hit = '0;
    keep       = '0;
    ncommitted = '0;
    for (int i = 0; i < LSB_SIZE; i++) begin
      commit_hit[i] = busy[i] && is_store[i] && (dest_from_rob_bus != '0) &&
                      (e_dest[i] == dest_from_rob_bus);
      keep[i]       = busy[i] && (committed[i] || commit_hit[i]);
      ncommitted    = ncommitted + CNT_W'(keep[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    pop       = 1'b0;
    bcast     = 1'b0;
    case (state)
      IDLE: begin
        if (head_ready && (!flush || is_store[head])) begin
          issue     = 1'b1;
          state_nxt = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (done_from_mem) begin
          state_nxt = IDLE;
          if (is_write_to_mem) begin
            pop = 1'b1;
          end else if (!flush) begin
            pop   = 1'b1;
            bcast = 1'b1;
          end
        end else if (flush && !is_write_to_mem) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (done_from_mem) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      is_store  <= '0;
      committed <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      for (int i = 0; i < LSB_SIZE; i++) begin
        e_funct3[i] <= '0;
        e_dest[i]   <= '0;
        e_qj[i]     <= '0;
        e_qk[i]     <= '0;
        e_vj[i]     <= '0;
        e_vk[i]     <= '0;
        e_imm[i]    <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < LSB_SIZE; i++) begin
        if (!flush && busy[i]) begin
          if (e_qj[i] != '0 && e_qj[i] == dest_from_rss_bus) begin
            e_qj[i] <= '0;
            e_vj[i] <= value_from_rss_bus;
          end else if (e_qj[i] != '0 && e_qj[i] == dest_to_lsb_bus) begin
            e_qj[i] <= '0;
            e_vj[i] <= value_to_lsb_bus;
          end
          if (e_qk[i] != '0 && e_qk[i] == dest_from_rss_bus) begin
            e_qk[i] <= '0;
            e_vk[i] <= value_from_rss_bus;
          end else if (e_qk[i] != '0 && e_qk[i] == dest_to_lsb_bus) begin
            e_qk[i] <= '0;
            e_vk[i] <= value_to_lsb_bus;
          end
        end
        if (commit_hit[i]) committed[i] <= 1'b1;
        if (flush && !keep[i]) begin
          busy[i]      <= 1'b0;
          committed[i] <= 1'b0;
        end
      end
      if (enq) begin
        busy[tail]      <= 1'b1;
        is_store[tail]  <= is_store_from_issuer;
        committed[tail] <= enq_commit;
        e_funct3[tail]  <= funct3_from_issuer;
        e_dest[tail]    <= dest_from_issuer;
        e_qj[tail]      <= enq_qj;
        e_vj[tail]      <= enq_vj;
        e_qk[tail]      <= enq_qk;
        e_vk[tail]      <= enq_vk;
        e_imm[tail]     <= imm_from_issuer;
      end
      if (pop) begin
        busy[head]      <= 1'b0;
        committed[head] <= 1'b0;
        head            <= head + IDX_W'(1);
      end
      if (flush) begin
        tail  <= head + ncommitted[IDX_W-1:0];
        count <= ncommitted - CNT_W'(pop);
      end else begin
        if (enq) tail <= tail + IDX_W'(1);
        count <= count + CNT_W'(enq) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_to_mem     <= 1'b0;
      is_write_to_mem  <= 1'b0;
      addr_to_mem      <= '0;
      data_to_mem      <= '0;
      funct3_to_mem    <= '0;
      dest_to_lsb_bus  <= '0;
      value_to_lsb_bus <= '0;
    end else if (rdy) begin
      dest_to_lsb_bus  <= '0;
      value_to_lsb_bus <= '0;
      if (issue) begin
        valid_to_mem    <= 1'b1;
        is_write_to_mem <= is_store[head];
        addr_to_mem     <= e_vj[head] + e_imm[head];
        data_to_mem     <= e_vk[head];
        funct3_to_mem   <= e_funct3[head];
      end else if (state != IDLE && done_from_mem) begin
        valid_to_mem <= 1'b0;
      end
      if (bcast) begin
        dest_to_lsb_bus  <= e_dest[head];
        value_to_lsb_bus <= ext_value;
      end
    end
  end

endmodule

// File: tb/tb_ld_st_buffer.sv
// Scoreboard bench for ld_st_buffer: stimulus queues expected memory requests
// and load broadcasts; a monitor compares them as the DUT presents them.
module tb_ld_st_buffer;
  import ld_st_buffer_pkg::*;

  logic        clk, rst, rdy, is_lsb_full;
  logic        valid_from_issuer, is_store_from_issuer;
  logic [2:0]  funct3_from_issuer;
  logic [3:0]  dest_from_issuer, qj_from_issuer, qk_from_issuer;
  logic [31:0] vj_from_issuer, vk_from_issuer, imm_from_issuer;
  logic [3:0]  dest_from_rss_bus;
  logic [31:0] value_from_rss_bus;
  logic [3:0]  dest_to_lsb_bus;
  logic [31:0] value_to_lsb_bus;
  logic        reset_from_rob_bus;
  logic [3:0]  dest_from_rob_bus;
  logic        valid_to_mem, is_write_to_mem;
  logic [31:0] addr_to_mem, data_to_mem;
  logic [2:0]  funct3_to_mem;
  logic        done_from_mem;
  logic [31:0] data_from_mem;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } req_t;
  typedef struct {
    logic [3:0]  dest;
    logic [31:0] value;
  } bc_t;

  req_t        exp_req_q[$];
  bc_t         exp_bc_q[$];
  logic [31:0] mem_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          mem_lat = 1;

  ld_st_buffer #(.LSB_SIZE(8), .ROB_ID_W(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .is_lsb_full(is_lsb_full),
    .valid_from_issuer(valid_from_issuer), .is_store_from_issuer(is_store_from_issuer),
    .funct3_from_issuer(funct3_from_issuer), .dest_from_issuer(dest_from_issuer),
    .qj_from_issuer(qj_from_issuer), .vj_from_issuer(vj_from_issuer),
    .qk_from_issuer(qk_from_issuer), .vk_from_issuer(vk_from_issuer),
    .imm_from_issuer(imm_from_issuer),
    .dest_from_rss_bus(dest_from_rss_bus), .value_from_rss_bus(value_from_rss_bus),
    .dest_to_lsb_bus(dest_to_lsb_bus), .value_to_lsb_bus(value_to_lsb_bus),
    .reset_from_rob_bus(reset_from_rob_bus), .dest_from_rob_bus(dest_from_rob_bus),
    .valid_to_mem(valid_to_mem), .is_write_to_mem(is_write_to_mem),
    .addr_to_mem(addr_to_mem), .data_to_mem(data_to_mem), .funct3_to_mem(funct3_to_mem),
    .done_from_mem(done_from_mem), .data_from_mem(data_from_mem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] got);
    vectors++;
    miscompares++;
    $display("FAIL %s: got 0x%08h, expected nothing", name, got);
  endtask

  // Memory model: answers each request after mem_lat cycles with a one-cycle done.
  initial begin
    logic w;
    done_from_mem = 1'b0;
    data_from_mem = '0;
    forever begin
      @(negedge clk);
      if (!rst && valid_to_mem) begin
        w = is_write_to_mem;
        repeat (mem_lat) @(posedge clk);
        #1;
        data_from_mem = (!w && mem_q.size() > 0) ? mem_q.pop_front() : 32'h0;
        done_from_mem = 1'b1;
        @(posedge clk);
        #1;
        done_from_mem = 1'b0;
        data_from_mem = '0;
      end
    end
  end

  // Monitor: compares every new request and every broadcast against the queues.
  initial begin
    logic prev_valid, prev_bc;
    req_t r;
    bc_t  b;
    prev_valid = 1'b0;
    prev_bc    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_bc    = 1'b0;
      end else begin
        if (valid_to_mem && !prev_valid) begin
          if (exp_req_q.size() == 0) begin
            unexpected("unexpected_req", addr_to_mem);
          end else begin
            r = exp_req_q.pop_front();
            check("req_is_write", 32'(is_write_to_mem), 32'(r.w));
            check("req_addr", addr_to_mem, r.addr);
            check("req_data", data_to_mem, r.data);
            check("req_funct3", 32'(funct3_to_mem), 32'(r.f3));
          end
        end
        prev_valid = valid_to_mem;
        if (dest_to_lsb_bus != '0) begin
          if (prev_bc) unexpected("bc_longer_than_pulse", 32'(dest_to_lsb_bus));
          else if (exp_bc_q.size() == 0) unexpected("unexpected_bc", 32'(dest_to_lsb_bus));
          else begin
            b = exp_bc_q.pop_front();
            check("bc_dest", 32'(dest_to_lsb_bus), 32'(b.dest));
            check("bc_value", value_to_lsb_bus, b.value);
          end
        end
        prev_bc = (dest_to_lsb_bus != '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic st, input logic [2:0] f3, input logic [3:0] d,
                           input logic [3:0] qj, input logic [31:0] vj,
                           input logic [3:0] qk, input logic [31:0] vk, input logic [31:0] imm);
    valid_from_issuer    = 1'b1;
    is_store_from_issuer = st;
    funct3_from_issuer   = f3;
    dest_from_issuer     = d;
    qj_from_issuer       = qj;
    vj_from_issuer       = vj;
    qk_from_issuer       = qk;
    vk_from_issuer       = vk;
    imm_from_issuer      = imm;
  endtask

  task automatic enq(input logic st, input logic [2:0] f3, input logic [3:0] d,
                     input logic [3:0] qj, input logic [31:0] vj,
                     input logic [3:0] qk, input logic [31:0] vk, input logic [31:0] imm);
    drive_enq(st, f3, d, qj, vj, qk, vk, imm);
    tick();
    valid_from_issuer = 1'b0;
  endtask

  task automatic rss(input logic [3:0] d, input logic [31:0] v);
    dest_from_rss_bus  = d;
    value_from_rss_bus = v;
    tick();
    dest_from_rss_bus  = '0;
    value_from_rss_bus = '0;
  endtask

  task automatic commit(input logic [3:0] d);
    dest_from_rob_bus = d;
    tick();
    dest_from_rob_bus = '0;
  endtask

  task automatic flush();
    reset_from_rob_bus = 1'b1;
    tick();
    reset_from_rob_bus = 1'b0;
  endtask

  task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f3);
    req_t r;
    r.w = w; r.addr = a; r.data = d; r.f3 = f3;
    exp_req_q.push_back(r);
  endtask

  task automatic push_bc(input logic [3:0] d, input logic [31:0] v);
    bc_t b;
    b.dest = d; b.value = v;
    exp_bc_q.push_back(b);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_req_q.size() != 0 || exp_bc_q.size() != 0 || valid_to_mem) && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(n >= 200), 32'h0);
    repeat (4) tick();
  endtask

  initial begin
    logic [31:0] fa [1:8];
    logic [31:0] fd [1:8];
    logic [2:0]  ff [1:8];
    logic [31:0] vj, imm;
    int          n;

    rst = 1'b1; rdy = 1'b1;
    valid_from_issuer = 1'b0; is_store_from_issuer = 1'b0; funct3_from_issuer = '0;
    dest_from_issuer = '0; qj_from_issuer = '0; vj_from_issuer = '0;
    qk_from_issuer = '0; vk_from_issuer = '0; imm_from_issuer = '0;
    dest_from_rss_bus = '0; value_from_rss_bus = '0;
    reset_from_rob_bus = 1'b0; dest_from_rob_bus = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_to_mem", 32'(valid_to_mem), 32'h0);
    check("rst_dest_to_lsb_bus", 32'(dest_to_lsb_bus), 32'h0);
    check("rst_is_lsb_full", 32'(is_lsb_full), 32'h0);
    check("rst_addr_to_mem", addr_to_mem, 32'h0);
    rst = 1'b0;
    tick();

    // Ready LW: addr 0x1000+4, broadcast of raw word.
    push_req(1'b0, 32'h1004, 32'h0, F3_LW);
    mem_q.push_back(32'hDEADBEEF);
    push_bc(4'd3, 32'hDEADBEEF);
    enq(1'b0, F3_LW, 4'd3, 4'd0, 32'h1000, 4'd0, 32'h0, 32'h4);
    wait_drain("drain_lw");

    // Extension cases, plus a store whose data comes from the LBU broadcast.
    push_req(1'b0, 32'h2000, 32'h0, F3_LB);  mem_q.push_back(32'h00000080); push_bc(4'd4,  32'hFFFFFF80);
    push_req(1'b0, 32'h2001, 32'h0, F3_LBU); mem_q.push_back(32'h00000080); push_bc(4'd6,  32'h00000080);
    push_req(1'b0, 32'h2002, 32'h0, F3_LH);  mem_q.push_back(32'h00018001); push_bc(4'd14, 32'hFFFF8001);
    push_req(1'b0, 32'h2003, 32'h0, F3_LHU); mem_q.push_back(32'h12348001); push_bc(4'd15, 32'h00008001);
    enq(1'b0, F3_LB,  4'd4,  4'd0, 32'h2000, 4'd0, 32'h0, 32'h0);
    enq(1'b0, F3_LBU, 4'd6,  4'd0, 32'h2000, 4'd0, 32'h0, 32'h1);
    enq(1'b0, F3_LH,  4'd14, 4'd0, 32'h2000, 4'd0, 32'h0, 32'h2);
    enq(1'b0, F3_LHU, 4'd15, 4'd0, 32'h2000, 4'd0, 32'h0, 32'h3);
    enq(1'b1, F3_SW,  4'd11, 4'd0, 32'h600,  4'd6, 32'h55, 32'h0);
    wait_drain("drain_ext");
    push_req(1'b1, 32'h600, 32'h80, F3_SW);
    commit(4'd11);
    wait_drain("drain_lsb_snoop_store");

    // Store waits for its base operand and then for its commit.
    enq(1'b1, F3_SW, 4'd5, 4'd2, 32'h999, 4'd0, 32'hCAFEF00D, 32'h10);
    repeat (3) tick();
    check("store_wait_qj", 32'(valid_to_mem), 32'h0);
    rss(4'd2, 32'h200);
    repeat (3) tick();
    check("store_wait_commit", 32'(valid_to_mem), 32'h0);
    push_req(1'b1, 32'h210, 32'hCAFEF00D, F3_SW);
    commit(4'd5);
    wait_drain("drain_store");

    // Committed store survives a flush; the loads behind it vanish.
    enq(1'b1, F3_SW, 4'd7, 4'd0, 32'h300, 4'd0, 32'h11, 32'h0);
    enq(1'b0, F3_LW, 4'd8, 4'd0, 32'h400, 4'd0, 32'h0, 32'h0);
    enq(1'b0, F3_LW, 4'd9, 4'd0, 32'h404, 4'd0, 32'h0, 32'h0);
    push_req(1'b1, 32'h300, 32'h11, F3_SW);
    commit(4'd7);
    flush();
    wait_drain("drain_flush_keep");

    // Flush with a load in flight: request held until done, result dropped.
    mem_lat = 5;
    push_req(1'b0, 32'h504, 32'h0, F3_LW);
    mem_q.push_back(32'h12345678);
    enq(1'b0, F3_LW, 4'd10, 4'd0, 32'h500, 4'd0, 32'h0, 32'h4);
    n = 0;
    do begin @(negedge clk); n++; end while (!valid_to_mem && n < 50);
    check("drain_req_seen", 32'(n >= 50), 32'h0);
    flush();
    check("drain_valid_held", 32'(valid_to_mem), 32'h1);
    wait_drain("drain_flushed_load");
    check("drain_no_reissue", 32'(valid_to_mem), 32'h0);
    mem_lat = 1;

    // Fill to 7 entries (tail wraps through index 0), then pop + enqueue.
    for (int k = 1; k <= 7; k++) begin
      vj  = (k == 3) ? 32'h2 : 32'(k) * 32'h100;
      imm = (k == 3) ? 32'hFFFFFFFC : 32'(k);
      fa[k] = vj + imm;
      fd[k] = 32'hA0 + 32'(k);
      ff[k] = (k % 3 == 0) ? F3_SB : ((k % 3 == 1) ? F3_SH : F3_SW);
      enq(1'b1, ff[k], 4'(k), 4'd0, vj, 4'd0, fd[k], imm);
      if (k == 6) check("full_at_6", 32'(is_lsb_full), 32'h0);
    end
    check("full_at_7", 32'(is_lsb_full), 32'h1);
    fa[8] = 32'h7024; fd[8] = 32'hABCD; ff[8] = F3_SW;
    push_req(1'b1, fa[1], fd[1], ff[1]);
    commit(4'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!done_from_mem && n < 50);
    check("pop_done_seen", 32'(n >= 50), 32'h0);
    drive_enq(1'b1, F3_SW, 4'd8, 4'd13, 32'h0, 4'd12, 32'h0, 32'h24);
    dest_from_rss_bus  = 4'd13;
    value_from_rss_bus = 32'h7000;
    tick();
    valid_from_issuer  = 1'b0;
    dest_from_rss_bus  = '0;
    value_from_rss_bus = '0;
    check("full_after_pop_enq", 32'(is_lsb_full), 32'h1);
    rss(4'd12, 32'hABCD);
    for (int k = 2; k <= 8; k++) push_req(1'b1, fa[k], fd[k], ff[k]);
    for (int k = 2; k <= 8; k++) commit(4'(k));
    wait_drain("drain_fill");
    check("empty_after_drain", 32'(is_lsb_full), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
